// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the core load/store path and the loader port.
// Optional statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              core_stall,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       stall_cnt
);

  // Handshake: a port's access happens in the cycle where req and ack are both high;
  // the requester holds req/addr/we/wdata until ack and may drop req beforehand to abandon.

  typedef enum logic [1:0] {IDLE, CORE, LOAD} owner_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  owner_t     owner_q, owner_d;
  owner_t     last_q, last_d;
  owner_t     prev;
  logic [7:0] bcnt_q, bcnt_d;
  logic       grant_c, grant_l;

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= IDLE;
      last_q  <= LOAD;
      bcnt_q  <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    grant_c = 1'b0;
    grant_l = 1'b0;
    owner_d = IDLE;
    last_d  = last_q;
    bcnt_d  = '0;
    prev    = (owner_q == IDLE) ? last_q : owner_q;
    // Reset gates every grant so nothing is acked or written during it.
    if (rst) begin
      if (c_req && !l_req) begin
        grant_c = 1'b1;
      end else if (!c_req && l_req) begin
        grant_l = 1'b1;
      end else if (c_req && l_req) begin
        if (owner_q == LOAD && l_lock && bcnt_q < MAX_B) grant_l = 1'b1;
        else if (prev == LOAD)                           grant_c = 1'b1;
        else                                             grant_l = 1'b1;
      end
    end
    if (grant_c) begin
      owner_d = CORE;
      last_d  = CORE;
    end else if (grant_l) begin
      owner_d = LOAD;
      last_d  = LOAD;
    end
    // Only a locked loader beat that beat the core extends the burst; all else restarts it.
    if (grant_l && c_req && l_lock) bcnt_d = (bcnt_q == MAX_B) ? bcnt_q : bcnt_q + 8'd1;
  end

  assign c_ack      = grant_c;
  assign l_ack      = grant_l;
  assign c_rdata    = mem_rd;
  assign l_rdata    = mem_rd;
  assign mem_a      = grant_l ? l_addr  : c_addr;
  assign mem_wd     = grant_l ? l_wdata : c_wdata;
  assign mem_we     = (grant_c & c_we) | (grant_l & l_we);
  assign core_stall = rst & c_req & ~grant_c;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conf_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      conf_q  <= '0;
      stall_q <= '0;
    end else begin
      if (c_req && l_req && conf_q != 16'hFFFF) conf_q  <= conf_q + 16'd1;
      if (core_stall && stall_q != 16'hFFFF)    stall_q <= stall_q + 16'd1;
    end
  end

  assign conflict_cnt = conf_q;
  assign stall_cnt    = stall_q;
`else
  assign conflict_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule
